// File: rtl/ob_drain.sv
// Output-buffer drain engine.
// Reads a run of rows from the output-buffer SRAM and streams them out over a
// valid/ready interface. A 2-entry skid FIFO absorbs the one-cycle read latency.
// Reads are credit-limited so the FIFO can never overflow under backpressure.
module ob_drain #(
    parameter int WIDTH  = 8,
    parameter int COL    = 4,
    parameter int O_SIZE = 256,
    localparam int AW    = $clog2(O_SIZE),
    localparam int DW    = COL * WIDTH
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   count_i,
    output logic          ob_mem_cenb_o,
    output logic          ob_mem_wenb_o,
    output logic [AW-1:0] ob_mem_addr_o,
    input  logic [DW-1:0] ob_mem_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StFlush,
        StDone
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_count;
    logic [AW:0]   r_issued;
    logic [AW-1:0] r_addr;
    logic          r_done;

    // One read may be in flight; it lands in the FIFO the cycle after issue.
    logic          r_inflight;
    logic          r_inflight_last;

    logic [DW-1:0] r_fifo_data [2];
    logic          r_fifo_last [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_fifo_cnt;

    logic          w_pop;
    logic          w_head_last;
    logic [2:0]    w_occ;
    logic          w_credit;
    logic          w_issue;
    logic          w_issue_last;
    logic [AW-1:0] w_addr_next;

    // Issue decision: projected FIFO occupancy after this cycle must leave room
    // for the read issued now.
    always_comb begin
        w_pop        = (r_fifo_cnt != 2'd0) && out_ready_i;
        w_head_last  = r_fifo_last[r_rd_ptr];
        w_occ        = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_credit     = (w_occ < 3'd2);
        w_issue      = (r_state == StRead) && (r_issued != r_count) && w_credit;
        w_issue_last = w_issue && ((r_issued + 1'b1) == r_count);
        w_addr_next  = (r_addr == AW'(O_SIZE - 1)) ? '0 : r_addr + 1'b1;
    end

    // Control FSM with address/count bookkeeping and registered done pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_issued <= '0;
            r_addr   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == StDone);
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_count  <= count_i;
                        r_issued <= '0;
                        if (count_i == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StRead;
                            r_addr  <= base_addr_i;
                        end
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_issued <= r_issued + 1'b1;
                        if (w_issue_last) begin
                            // Address stays on the final row once all reads are out.
                            r_state <= StFlush;
                        end else begin
                            r_addr <= w_addr_next;
                        end
                    end
                end
                StFlush: begin
                    if (w_pop && w_head_last) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Track the read issued last cycle so its data is captured when valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
        end
    end

    // Two-entry FIFO between SRAM read data and the output stream.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= ob_mem_data_i;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Output drive; memory strobes come straight from the issue decision.
    always_comb begin
        ob_mem_cenb_o = ~w_issue;
        ob_mem_wenb_o = 1'b1;
        ob_mem_addr_o = r_addr;
        out_valid_o   = (r_fifo_cnt != 2'd0);
        out_data_o    = r_fifo_data[r_rd_ptr];
        out_last_o    = (r_fifo_cnt != 2'd0) && r_fifo_last[r_rd_ptr];
        busy_o        = (r_state != StIdle);
        done_o        = r_done;
    end

endmodule
